// File: rtl/pentary_regfile_mp.sv
// -----------------------------------------------------------------------------
// pentary_regfile_mp
//   Multi-port register file for the pentary core. It sits between decode/issue
//   and writeback and provides:
//     - NUM_RD combinational read ports (latency 0)
//     - NUM_WR write ports; highest port index wins on an address collision
//     - optional hardwired-zero R0 and optional write-to-read bypass
//     - a per-register pending scoreboard (reserve sets, write clears)
//     - a clear engine that zeroes one entry per cycle after clr_req
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   rd_addr      NUM_RD packed read addresses, port p at [p*AW +: AW]
//   rd_data      NUM_RD packed read data, port p at [p*DATA_W +: DATA_W]
//   rd_pending   pending bit of the register addressed by each read port
//   wr_en        per-port write enables
//   wr_addr      NUM_WR packed write addresses
//   wr_data      NUM_WR packed write data
//   wr_ready     1 when writes are accepted (low during a clear sweep)
//   rsv_en       reserve register rsv_addr (set its pending bit)
//   rsv_addr     register to reserve
//   clr_req      start a clear sweep (level, sampled only when idle)
//   clr_busy     clear sweep in progress
//   clr_done     one-cycle pulse when the sweep completes
//   wr_conflict  registered pulse: two or more ports wrote the same register
// -----------------------------------------------------------------------------
module pentary_regfile_mp #(
  parameter int NUM_REGS    = 32,
  parameter int DATA_W      = 48,
  parameter int NUM_RD      = 4,
  parameter int NUM_WR      = 2,
  parameter bit ZERO_REG_EN = 1'b1,
  parameter bit BYPASS_EN   = 1'b1,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     wr_ready,
  input  logic                     rsv_en,
  input  logic [AW-1:0]            rsv_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     wr_conflict
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

  clr_state_e          state;
  logic [AW-1:0]       idx;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;

  logic [AW-1:0]       rd_addr_a [NUM_RD];
  logic [AW-1:0]       wr_addr_a [NUM_WR];
  logic [DATA_W-1:0]   wr_data_a [NUM_WR];
  logic                conflict_c;

  // R0 is read-only zero when the zero register is enabled.
  function automatic logic writable(input logic [AW-1:0] a);
    return !ZERO_REG_EN || (a != '0);
  endfunction

  assign wr_ready = ~clr_busy;

  // Unpack the flat port vectors once so the rest of the logic reads cleanly.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) rd_addr_a[p] = rd_addr[p*AW +: AW];
    for (int k = 0; k < NUM_WR; k++) begin
      wr_addr_a[k] = wr_addr[k*AW +: AW];
      wr_data_a[k] = wr_data[k*DATA_W +: DATA_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Clear engine. Outputs are registered with the state so clr_busy is high
  // for exactly the NUM_REGS SWEEP cycles and clr_done for the single DONE cycle.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clr_req) begin
            state    <= ST_SWEEP;
            idx      <= '0;
            clr_busy <= 1'b1;
          end
        end
        ST_SWEEP: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state    <= ST_DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        ST_DONE: begin
          // clr_req is deliberately ignored here; a new sweep starts from IDLE.
          state <= ST_IDLE;
        end
        default: begin
          state    <= ST_IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Register array and scoreboard. Statement order sets priority: later
  // assignments override earlier ones within the same edge, so
  //   write port k (ascending) < reservation < sweep clear.
  // ---------------------------------------------------------------------------
  // NOTE: the array is reset asynchronously because a reset mid-sweep must
  // leave every register zero immediately; this rules out an SRAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      pending <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && wr_ready && writable(wr_addr_a[k])) begin
          regs[wr_addr_a[k]]    <= wr_data_a[k];
          pending[wr_addr_a[k]] <= 1'b0;
        end
      end
      if (rsv_en && writable(rsv_addr)) pending[rsv_addr] <= 1'b1;
      if (state == ST_SWEEP) begin
        regs[idx]    <= '0;
        pending[idx] <= 1'b0;
      end
    end
  end

  // Conflict: any pair of accepted writes to the same writable register.
  always_comb begin
    conflict_c = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] && (wr_addr_a[i] == wr_addr_a[j]) &&
            writable(wr_addr_a[i]))
          conflict_c = 1'b1;
      end
    end
    conflict_c = conflict_c & wr_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wr_conflict <= 1'b0;
    else          wr_conflict <= conflict_c;
  end

  // ---------------------------------------------------------------------------
  // Read ports. Bypass is qualified by reset_n so nothing leaks out during
  // reset; the stored array is already zero then.
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default at the top of the block so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (reset_n && writable(rd_addr_a[p])) begin
        rd_data[p*DATA_W +: DATA_W] = regs[rd_addr_a[p]];
        if (BYPASS_EN && wr_ready) begin
          // Ascending scan: the highest matching port is assigned last and wins.
          for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && (wr_addr_a[k] == rd_addr_a[p]))
              rd_data[p*DATA_W +: DATA_W] = wr_data_a[k];
          end
        end
        rd_pending[p] = pending[rd_addr_a[p]];
      end
    end
  end

endmodule

// File: tb/tb_pentary_regfile_mp.sv
module tb_pentary_regfile_mp;

  localparam int NR = 32;
  localparam int DW = 48;
  localparam int NRD = 4;
  localparam int NWR = 2;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_pending;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              wr_ready;
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic              clr_req;
  logic              clr_busy;
  logic              clr_done;
  logic              wr_conflict;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  pentary_regfile_mp dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_pending  (rd_pending),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .rsv_en      (rsv_en),
    .rsv_addr    (rsv_addr),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .wr_conflict (wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int k, input logic en, input int a, input logic [DW-1:0] d);
    wr_en[k]            = en;
    wr_addr[k*AW +: AW] = AW'(a);
    wr_data[k*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rd(input int p);
    return rd_data[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] fill_val(input int i);
    return DW'(i) * 48'h1111;
  endfunction

  task automatic fill_all();
    for (int i = 1; i < NR; i++) begin
      set_wr(0, 1'b1, i, fill_val(i));
      tick();
    end
    wr_en = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;

    // Bypass must be suppressed while reset is asserted.
    set_wr(0, 1'b1, 5, 48'hDEAD_BEEF_0001);
    set_rd(0, 5);
    #1;
    check("rst_bypass_suppressed", 64'(rd(0)), 64'h0);
    wr_en = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("rst_wr_ready", 64'(wr_ready), 64'h1);
    check("rst_clr_busy", 64'(clr_busy), 64'h0);
    check("rst_clr_done", 64'(clr_done), 64'h0);
    check("rst_wr_conflict", 64'(wr_conflict), 64'h0);

    // 1. All registers zero, nothing pending.
    for (int a = 0; a < NR; a++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, (a + p) % NR);
      #1;
      check("t1_rd_data_zero", 64'(rd_data != '0), 64'h0);
      check("t1_rd_pending_zero", 64'(rd_pending), 64'h0);
    end

    // 2. Bypass in the write cycle, stored value afterwards.
    tick();
    set_wr(0, 1'b1, 5, 48'h1234_5678_9ABC);
    set_rd(0, 5); set_rd(1, 5); set_rd(2, 6);
    #1;
    check("t2_bypass_p0", 64'(rd(0)), 64'h1234_5678_9ABC);
    check("t2_bypass_p1", 64'(rd(1)), 64'h1234_5678_9ABC);
    check("t2_no_bypass_other", 64'(rd(2)), 64'h0);
    tick();
    wr_en = '0;
    #1;
    check("t2_stored", 64'(rd(0)), 64'h1234_5678_9ABC);
    check("t2_no_conflict", 64'(wr_conflict), 64'h0);

    // 3. Two ports write R7: port 1 wins, conflict pulses one cycle.
    set_wr(0, 1'b1, 7, 48'h1111_1111_1111);
    set_wr(1, 1'b1, 7, 48'h2222_2222_2222);
    set_rd(2, 7);
    #1;
    check("t3_bypass_highest", 64'(rd(2)), 64'h2222_2222_2222);
    tick();
    wr_en = '0;
    #1;
    check("t3_stored", 64'(rd(2)), 64'h2222_2222_2222);
    check("t3_conflict_pulse", 64'(wr_conflict), 64'h1);
    tick();
    check("t3_conflict_clear", 64'(wr_conflict), 64'h0);

    // 4. R0 ignores writes and reservations; no conflict on R0.
    set_wr(0, 1'b1, 0, 48'hFFFF_FFFF_FFFF);
    set_wr(1, 1'b1, 0, 48'hFFFF_FFFF_FFFF);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    set_rd(3, 0);
    #1;
    check("t4_r0_no_bypass", 64'(rd(3)), 64'h0);
    tick();
    wr_en = '0; rsv_en = 1'b0;
    #1;
    check("t4_r0_data", 64'(rd(3)), 64'h0);
    check("t4_r0_pending", 64'(rd_pending[3]), 64'h0);
    check("t4_r0_no_conflict", 64'(wr_conflict), 64'h0);

    // 5. Scoreboard on R9.
    rsv_en = 1'b1; rsv_addr = 5'd9;
    set_rd(0, 9);
    #1;
    check("t5_pending_not_bypassed", 64'(rd_pending[0]), 64'h0);
    tick();
    rsv_en = 1'b0;
    #1;
    check("t5_pending_set", 64'(rd_pending[0]), 64'h1);
    set_wr(1, 1'b1, 9, 48'h0000_0000_0099);
    tick();
    wr_en = '0;
    #1;
    check("t5_pending_cleared", 64'(rd_pending[0]), 64'h0);
    set_wr(0, 1'b1, 9, 48'h0000_0000_0909);
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    wr_en = '0; rsv_en = 1'b0;
    #1;
    check("t5_rsv_wins", 64'(rd_pending[0]), 64'h1);
    check("t5_data_written", 64'(rd(0)), 64'h0000_0000_0909);

    // 6. Fill, then sweep.
    fill_all();
    for (int p = 0; p < NRD; p++) set_rd(p, 31 - p);
    #1;
    check("t6_fill_r31", 64'(rd(0)), 64'(fill_val(31)));
    check("t6_fill_r28", 64'(rd(3)), 64'(fill_val(28)));
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    busy_cnt = 0;
    while (clr_busy === 1'b1 && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 10) begin
        // idx is 9 here: R3 already swept, R20 not yet.
        set_wr(0, 1'b1, 3, 48'h0000_0000_0ABC);
        rsv_en = 1'b1; rsv_addr = 5'd5;
        set_rd(0, 3); set_rd(1, 20);
        #1;
        check("t6_wr_ready_low", 64'(wr_ready), 64'h0);
        check("t6_no_bypass_sweep", 64'(rd(0)), 64'h0);
        check("t6_partial_r20", 64'(rd(1)), 64'(fill_val(20)));
        check("t6_no_done_mid", 64'(clr_done), 64'h0);
      end else if (busy_cnt == 11) begin
        // Reservation of the entry being swept this cycle is lost.
        wr_en = '0;
        rsv_en = 1'b1; rsv_addr = 5'd10;
      end else begin
        wr_en = '0;
        rsv_en = 1'b0;
      end
      tick();
    end
    wr_en = '0; rsv_en = 1'b0;
    check("t6_busy_cycles", 64'(busy_cnt), 64'd32);
    check("t6_done_pulse", 64'(clr_done), 64'h1);
    check("t6_ready_after", 64'(wr_ready), 64'h1);
    tick();
    check("t6_done_one_cycle", 64'(clr_done), 64'h0);
    check("t6_idle_busy", 64'(clr_busy), 64'h0);
    for (int a = 0; a < NR; a++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, a);
      #1;
      check("t6_cleared_data", 64'(rd_data != '0), 64'h0);
      check("t6_cleared_pending", 64'(rd_pending), (a == 5) ? 64'hF : 64'h0);
    end

    // Repeat sweep aborted by reset at cycle 10.
    fill_all();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (9) tick();
    check("t6b_busy_at_10", 64'(clr_busy), 64'h1);
    reset_n = 1'b0;
    #1;
    check("t6b_abort_busy", 64'(clr_busy), 64'h0);
    check("t6b_abort_ready", 64'(wr_ready), 64'h1);
    tick();
    reset_n = 1'b1;
    tick();
    check("t6b_idle_busy", 64'(clr_busy), 64'h0);
    check("t6b_idle_done", 64'(clr_done), 64'h0);
    for (int a = 0; a < NR; a++) begin
      for (int p = 0; p < NRD; p++) set_rd(p, a);
      #1;
      check("t6b_cleared_data", 64'(rd_data != '0), 64'h0);
      check("t6b_cleared_pending", 64'(rd_pending), 64'h0);
    end
    // Still idle, and writes are accepted again.
    set_wr(1, 1'b1, 12, 48'h0000_0000_ABCD);
    set_rd(0, 12);
    tick();
    wr_en = '0;
    #1;
    check("t6b_write_after_reset", 64'(rd(0)), 64'h0000_0000_ABCD);
    check("t6b_still_idle", 64'(clr_busy), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
